// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter
//   N-requester to single-slave Avalon-MM arbiter with zero added latency.
//   In IDLE the winner is picked combinationally and forwarded the same
//   cycle. If the slave stalls, the winner is locked as owner until the
//   slave releases waitrequest or the owner drops its strobes.
//
//   Build option: define ARB_ROUND_ROBIN_EN for round-robin priority
//   (search starts at last_grant+1 and wraps). Otherwise the lowest index
//   wins and no last_grant register exists.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   m_read/m_write        [N]       per-requester strobes
//   m_address             [N*AW]    requester i at [i*AW +: AW]
//   m_byte_enable         [N*DW/8]  same packing
//   m_writedata           [N*DW]    same packing
//   m_readdata            [N*DW]    s_readdata broadcast to every lane
//   m_waitrequest         [N]       s_waitrequest for the forwarded lane, else 1
//   s_read/s_write/s_address/s_byte_enable/s_writedata   shared slave request
//   s_readdata, s_waitrequest       shared slave response
//   grant                 [N]       one-hot forwarded requester, 0 if none
//   busy                            high while LOCKED

// Per-requester response/strobe logic.
module avalon_arb_lane #(
  parameter int DW = 32
) (
  input  logic          rd_i,
  input  logic          wr_i,
  input  logic          fwd_i,
  input  logic          s_wait_i,
  input  logic [DW-1:0] s_rdata_i,
  output logic          req_o,
  output logic          m_wait_o,
  output logic [DW-1:0] m_rdata_o
);
  assign req_o     = rd_i | wr_i;
  // A lane that is not forwarded is always stalled, requesting or not.
  assign m_wait_o  = fwd_i ? s_wait_i : 1'b1;
  assign m_rdata_o = s_rdata_i;
endmodule

module avalon_bus_arbiter #(
  parameter int N  = 3,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      m_read,
  input  logic [N-1:0]      m_write,
  input  logic [N*AW-1:0]   m_address,
  input  logic [N*DW/8-1:0] m_byte_enable,
  input  logic [N*DW-1:0]   m_writedata,
  output logic [N*DW-1:0]   m_readdata,
  output logic [N-1:0]      m_waitrequest,
  output logic              s_read,
  output logic              s_write,
  output logic [AW-1:0]     s_address,
  output logic [DW/8-1:0]   s_byte_enable,
  output logic [DW-1:0]     s_writedata,
  input  logic [DW-1:0]     s_readdata,
  input  logic              s_waitrequest,
  output logic [N-1:0]      grant,
  output logic              busy
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = DW / 8;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;

  logic [N-1:0]  req;
  logic [N-1:0]  fwd_oh;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] fwd_idx;
  logic          fwd_vld;
  logic          complete;

  logic [AW-1:0] addr_a [N];
  logic [BW-1:0] be_a   [N];
  logic [DW-1:0] wdat_a [N];

  // Lanes: unpack requester buses and build per-lane responses.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign addr_a[i] = m_address[i*AW +: AW];
    assign be_a[i]   = m_byte_enable[i*BW +: BW];
    assign wdat_a[i] = m_writedata[i*DW +: DW];

    avalon_arb_lane #(.DW(DW)) u_lane (
      .rd_i      (m_read[i]),
      .wr_i      (m_write[i]),
      .fwd_i     (fwd_oh[i]),
      .s_wait_i  (s_waitrequest),
      .s_rdata_i (s_readdata),
      .req_o     (req[i]),
      .m_wait_o  (m_waitrequest[i]),
      .m_rdata_o (m_readdata[i*DW +: DW])
    );
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] last_grant_q, last_grant_d;

  // Search from last_grant+1 upward, wrapping at N-1.
  always_comb begin
    logic found;
    int   j;
    found   = 1'b0;
    j       = 0;
    win_idx = '0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_grant_q) + k) % N;
      if (!found && req[j]) begin
        win_idx = IW'(j);
        found   = 1'b1;
      end
    end
  end

  // Pointer moves only on a completing cycle.
  always_comb begin
    last_grant_d = last_grant_q;
    if (complete) last_grant_d = fwd_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= IW'(N - 1);
    else        last_grant_q <= last_grant_d;
  end
`else
  // Fixed priority: lowest index wins.
  always_comb begin
    win_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) win_idx = IW'(i);
    end
  end
`endif

  // What is forwarded this cycle: the fresh winner in IDLE, only the
  // locked owner in LOCKED (nothing if the owner dropped its strobes).
  always_comb begin
    fwd_vld = 1'b0;
    fwd_idx = win_idx;
    if (state_q == IDLE) begin
      fwd_vld = |req;
      fwd_idx = win_idx;
    end else begin
      fwd_vld = req[owner_q];
      fwd_idx = owner_q;
    end
  end

  assign complete = fwd_vld & ~s_waitrequest;

  // Slave-side mux; all zero when nothing is forwarded.
  always_comb begin
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_address     = '0;
    s_byte_enable = '0;
    s_writedata   = '0;
    fwd_oh        = '0;
    if (fwd_vld) begin
      s_read          = m_read[fwd_idx];
      s_write         = m_write[fwd_idx];
      s_address       = addr_a[fwd_idx];
      s_byte_enable   = be_a[fwd_idx];
      s_writedata     = wdat_a[fwd_idx];
      fwd_oh[fwd_idx] = 1'b1;
    end
  end

  assign grant = fwd_oh;
  assign busy  = (state_q == LOCKED);

  // Next-state: lock on a stalled IDLE transfer, release on completion
  // or on the owner abandoning the transfer.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (fwd_vld && s_waitrequest) begin
          state_d = LOCKED;
          owner_d = win_idx;
        end
      end
      LOCKED: begin
        if (!fwd_vld || !s_waitrequest) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter (N=3, AW=DW=32). Inputs change on
// the falling edge; combinational outputs are checked 1ns later, so each
// check sees the state registered at the preceding rising edge.
module tb_avalon_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      m_read, m_write;
  logic [N*AW-1:0]   m_address;
  logic [N*DW/8-1:0] m_byte_enable;
  logic [N*DW-1:0]   m_writedata;
  logic [N*DW-1:0]   m_readdata;
  logic [N-1:0]      m_waitrequest;
  logic              s_read, s_write;
  logic [AW-1:0]     s_address;
  logic [DW/8-1:0]   s_byte_enable;
  logic [DW-1:0]     s_writedata;
  logic [DW-1:0]     s_readdata;
  logic              s_waitrequest;
  logic [N-1:0]      grant;
  logic              busy;

  int total = 0;
  int bad   = 0;

  avalon_bus_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_address     (m_address),
    .m_byte_enable (m_byte_enable),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .m_waitrequest (m_waitrequest),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_address     (s_address),
    .s_byte_enable (s_byte_enable),
    .s_writedata   (s_writedata),
    .s_readdata    (s_readdata),
    .s_waitrequest (s_waitrequest),
    .grant         (grant),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Next falling edge, apply strobes and slave wait, then let comb settle.
  task automatic step(input logic [N-1:0] rd, input logic [N-1:0] wr, input logic sw);
    @(negedge clk);
    m_read        = rd;
    m_write       = wr;
    s_waitrequest = sw;
    #1;
  endtask

  logic [N-1:0] exp_g;

  initial begin
    rst_n         = 1'b0;
    m_read        = '0;
    m_write       = '0;
    m_address     = '0;
    m_byte_enable = '0;
    m_writedata   = '0;
    s_readdata    = 32'hDEADBEEF;
    s_waitrequest = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_address[i*AW +: AW]       = 32'h1000 * (i + 1);
      m_byte_enable[i*DW/8 +: 4]  = 4'h1 << i;
      m_writedata[i*DW +: DW]     = 32'hCAFE0000 + i;
    end
    m_address[2*AW +: AW] = 32'h100;

    // Reset state, idle outputs
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 3'b000);
    chk("rst_sread", s_read, 1'b0);
    chk("rst_saddr", s_address, 32'h0);
    chk("rst_mwait", m_waitrequest, 3'b111);
    chk("rst_rdata", m_readdata, {3{32'hDEADBEEF}});
    // Outputs still follow IDLE rules while in reset
    m_read = 3'b100;
    #1;
    chk("rst_fwd_grant", grant, 3'b100);
    chk("rst_fwd_busy", busy, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    rst_n = 1'b1;

    // Two requesters, zero-wait slave
    step(3'b110, 3'b000, 1'b0);
    chk("two_c1_grant", grant, 3'b010);
    chk("two_c1_mwait", m_waitrequest, 3'b101);
    chk("two_c1_sread", s_read, 1'b1);
    chk("two_c1_saddr", s_address, 32'h2000);
    step(3'b110, 3'b000, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = 3'b100;
`else
    exp_g = 3'b010;
`endif
    chk("two_c2_grant", grant, exp_g);
    step(3'b110, 3'b000, 1'b0);
    chk("two_c3_grant", grant, 3'b010);

    // Single write with three wait cycles
    step(3'b000, 3'b100, 1'b1);
    chk("wr_a_grant", grant, 3'b100);
    chk("wr_a_busy", busy, 1'b0);
    chk("wr_a_mwait", m_waitrequest, 3'b111);
    chk("wr_a_swrite", s_write, 1'b1);
    chk("wr_a_sbe", s_byte_enable, 4'h4);
    chk("wr_a_swdata", s_writedata, 32'hCAFE0002);
    step(3'b000, 3'b100, 1'b1);
    chk("wr_b_busy", busy, 1'b1);
    chk("wr_b_saddr", s_address, 32'h100);
    chk("wr_b_mwait", m_waitrequest, 3'b111);
    step(3'b000, 3'b100, 1'b1);
    chk("wr_c_busy", busy, 1'b1);
    chk("wr_c_saddr", s_address, 32'h100);
    step(3'b000, 3'b100, 1'b0);
    chk("wr_d_busy", busy, 1'b1);
    chk("wr_d_saddr", s_address, 32'h100);
    chk("wr_d_mwait", m_waitrequest, 3'b011);
    step(3'b000, 3'b000, 1'b0);
    chk("wr_e_busy", busy, 1'b0);
    chk("wr_e_grant", grant, 3'b000);
    chk("wr_e_saddr", s_address, 32'h0);

    // Higher-priority request arrives while locked on requester 1
    step(3'b010, 3'b000, 1'b1);
    chk("lk_a_grant", grant, 3'b010);
    step(3'b011, 3'b000, 1'b1);
    chk("lk_b_grant", grant, 3'b010);
    chk("lk_b_busy", busy, 1'b1);
    chk("lk_b_mwait", m_waitrequest, 3'b111);
    step(3'b011, 3'b000, 1'b0);
    chk("lk_c_grant", grant, 3'b010);
    chk("lk_c_mwait", m_waitrequest, 3'b101);
    step(3'b011, 3'b000, 1'b0);
    chk("lk_d_grant", grant, 3'b001);
    chk("lk_d_busy", busy, 1'b0);

    // Owner abandons a locked transfer; pointer must not move
    step(3'b100, 3'b000, 1'b1);
    chk("ab_a_grant", grant, 3'b100);
    step(3'b001, 3'b000, 1'b1);
    chk("ab_b_sread", s_read, 1'b0);
    chk("ab_b_grant", grant, 3'b000);
    chk("ab_b_busy", busy, 1'b1);
    chk("ab_b_mwait", m_waitrequest, 3'b111);
    step(3'b101, 3'b000, 1'b0);
    chk("ab_c_busy", busy, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = 3'b100;
`else
    exp_g = 3'b001;
`endif
    chk("ab_c_grant", grant, exp_g);

    // Reset while locked on requester 2
    step(3'b100, 3'b000, 1'b1);
    step(3'b100, 3'b000, 1'b1);
    chk("rl_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rl_rst_busy", busy, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    rst_n = 1'b1;
    step(3'b101, 3'b000, 1'b0);
    chk("rl_post_grant", grant, 3'b001);

    // All three requesting continuously from reset
    step(3'b000, 3'b000, 1'b0);
    rst_n = 1'b0;
    step(3'b000, 3'b000, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(3'b111, 3'b000, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = (c == 3) ? 3'b001 : (3'b001 << c);
`else
      exp_g = 3'b001;
`endif
      chk($sformatf("all_c%0d_grant", c), grant, exp_g);
    end
    step(3'b000, 3'b000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/avalon_bus_arbiter.md
AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

Interface
REQ-001 Parameter N, default 3: number of requesters (index 0 = debug, 1 = dbus, 2 = ibus in the SoC), N >= 2.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width; byte enable width is DW/8.
REQ-004 Port clk  input  1: single clock, all logic rising-edge.
REQ-005 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 Port m_read / m_write  input  N each: per-requester read and write strobes, bit i = requester i.
REQ-007 Port m_address  input  N*AW: requester i at bits [i*AW +: AW].
REQ-008 Port m_byte_enable  input  N*DW/8; m_writedata  input  N*DW: same packing as m_address.
REQ-009 Port m_readdata  output  N*DW; m_waitrequest  output  N: per-requester response.
REQ-010 Port s_read, s_write  output  1; s_address  output  AW; s_byte_enable  output  DW/8; s_writedata  output  DW: shared slave request.
REQ-011 Port s_readdata  input  DW; s_waitrequest  input  1: shared slave response.
REQ-012 Port grant  output  N: one-hot current owner, all-zero when nothing is forwarded.
REQ-013 Port busy  output  1: high while in LOCKED state.

Function
REQ-014 Requester i is requesting when m_read[i] | m_write[i].
REQ-015 FSM has two states: IDLE and LOCKED, with a registered owner index.
REQ-016 In IDLE, the winner is chosen combinationally from the current requests and is forwarded to the slave in the same cycle, with zero added latency.
REQ-017 In IDLE with no requests, s_read = s_write = 0, grant = 0, and the other s_* outputs are 0.
REQ-018 In IDLE, if s_waitrequest = 0 while forwarding, the transfer completes in that cycle, and the FSM stays IDLE.
REQ-019 In IDLE, if s_waitrequest = 1 while forwarding, the owner is registered and the FSM enters LOCKED.
REQ-020 In LOCKED, only the owner is forwarded; new requests do not change the owner.
REQ-021 In LOCKED, when s_waitrequest = 0, the transfer completes and the FSM returns to IDLE next cycle.
REQ-022 In LOCKED, if the owner drops both strobes (protocol violation), nothing is forwarded and the FSM returns to IDLE next cycle.
REQ-023 m_waitrequest[i] = s_waitrequest when i is forwarded, otherwise 1, including when i is not requesting.
REQ-024 m_readdata[i] = s_readdata for every i; it is meaningful only to the forwarded requester.
REQ-025 Read and write both high on the owner are forwarded unchanged; the arbiter does not police this.
REQ-026 Arbitration pointer last_grant is updated to the winner on every completing cycle, and only then.
REQ-027 One transfer per requester per win; back-to-back zero-wait transfers from different requesters are possible every cycle.

Reset
REQ-028 While rst_n = 0: state = IDLE, owner = 0, last_grant = N-1, busy = 0.
REQ-029 A reset mid-LOCKED aborts the transfer; after release, arbitration restarts from the reset priority.
REQ-030 Outputs are combinational from state and inputs, so during reset they follow the IDLE rules in REQ-016 to REQ-017.

Configuration
REQ-031 Macro ARB_ROUND_ROBIN_EN.
REQ-032 With ARB_ROUND_ROBIN_EN defined: round-robin priority, searching from index last_grant+1 upward and wrapping at N-1 to 0.
REQ-033 Without ARB_ROUND_ROBIN_EN: fixed priority, lowest index wins; last_grant is not implemented.

Verification
REQ-034 Reset, then m_read = 3'b110 with s_waitrequest = 0 -> cycle 1 grant = 3'b010; then 3'b100 (RR) or 3'b010 every cycle (fixed).
REQ-035 Single request: m_write[2] = 1, address 0x100, s_waitrequest high 3 cycles -> busy = 1 for 3 cycles, s_address = 0x100 throughout, m_waitrequest = 3'b111 then 3'b011.
REQ-036 During LOCKED on requester 1, raise m_read[0] -> grant stays 3'b010 until completion; then 3'b001 next IDLE cycle.
REQ-037 All three requesters continuously requesting, zero-wait slave, RR build -> grant sequence 001, 010, 100, 001.
REQ-038 Assert rst_n = 0 while LOCKED on requester 2 -> busy = 0 immediately; after release, requests 3'b101 -> grant = 3'b001.
REQ-039 Owner drops strobes while LOCKED -> s_read = s_write = 0 that cycle, state IDLE next cycle, last_grant unchanged.
